// File: rtl/qei_step_decoder.sv
// -----------------------------------------------------------------------------
// qei_step_decoder
//
// Quadrature encoder front end. Raw A/B pins are brought into the clk domain,
// glitch-filtered per channel, and decoded into one-cycle step pulses with a
// direction flag. Double transitions (both channels changing at once) are
// flagged on err and counted in a saturating counter. The downstream position
// counter consumes step/dir directly and does no edge detection itself.
//
// Handshake: there is no valid/ready pairing here. step and err are
// single-cycle strobes, mutually exclusive, and valid on the cycle they are
// high. dir is a level that changes only in the cycle where step is high.
//
// Ports
//   clk      in   1      system clock
//   rst_n    in   1      synchronous, active-low reset
//   ena      in   1      enable; low suppresses step/err and err_cnt updates
//   a_in     in   1      raw encoder channel A (asynchronous)
//   b_in     in   1      raw encoder channel B (asynchronous)
//   clr_err  in   1      synchronous clear of err_cnt (wins over increment)
//   step     out  1      one-cycle pulse per legal quadrature transition
//   dir      out  1      1 = forward, 0 = backward
//   err      out  1      one-cycle pulse on an illegal double transition
//   ab_filt  out  2      filtered {A,B}
//   err_cnt  out  ERR_W  saturating count of err pulses
// -----------------------------------------------------------------------------
module qei_step_decoder #(
  parameter int FILT_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr_err,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [1:0]       ab_filt,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

  // Bit 1 carries channel A, bit 0 carries channel B throughout.
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [CNT_W-1:0] r_cnt [2];
  logic [1:0]       r_filt;
  logic [1:0]       r_prev;
  logic             r_step;
  logic             r_dir;
  logic             r_err;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_primed;
  logic [1:0]       r_fill;

  logic [1:0] w_diff;
  logic       w_legal;
  logic       w_illegal;
  logic       w_fwd;
  logic       w_live;
  logic       w_step;
  logic       w_err;
  logic       w_settled;

  // ---------------------------------------------------------------------------
  // Synchroniser and per-channel filter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_filt  <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= {a_in, b_in};
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_filt[i] <= r_sync2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  // Legal Gray steps change exactly one bit. For a single-bit change the move
  // is forward exactly when old A differs from new B (00->01, 01->11, 11->10,
  // 10->00); every backward step has old A equal to new B.
  assign w_diff    = r_prev ^ r_filt;
  assign w_legal   = (w_diff == 2'b01) || (w_diff == 2'b10);
  assign w_illegal = (w_diff == 2'b11);
  assign w_fwd     = r_prev[1] ^ r_filt[0];
  assign w_live    = r_primed & ena;
  assign w_step    = w_live & w_legal;
  assign w_err     = w_live & w_illegal;

  // The first two cycles after reset the synchroniser still holds its reset
  // zeros rather than pin samples, so "sync2 == filt" would look settled even
  // with the pins at 11. r_fill holds off priming until real samples have
  // reached sync2; after that, priming waits for both filters to be idle and
  // agreeing with their inputs.
  assign w_settled = (r_fill == 2'd2) &&
                     (r_cnt[0] == '0) && (r_cnt[1] == '0) &&
                     (r_sync2 == r_filt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev    <= 2'b00;
      r_step    <= 1'b0;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
      r_primed  <= 1'b0;
      r_fill    <= 2'd0;
    end else begin
      // prev always follows the filter, even while unprimed or disabled, so
      // no stale history can produce a burst later.
      r_prev <= r_filt;
      r_step <= w_step;
      r_err  <= w_err;

      if (w_step) begin
        r_dir <= w_fwd;
      end

      if (r_fill != 2'd2) begin
        r_fill <= r_fill + 2'd1;
      end

      if (!r_primed && w_settled) begin
        r_primed <= 1'b1;
      end

      if (clr_err) begin
        r_err_cnt <= '0;
      end else if (w_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_W'(1);
      end
    end
  end

  assign step    = r_step;
  assign dir     = r_dir;
  assign err     = r_err;
  assign ab_filt = r_filt;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_qei_step_decoder.sv
// -----------------------------------------------------------------------------
// tb_qei_step_decoder
//
// Drives encoder patterns into qei_step_decoder. Each driven transition that
// should survive the filter pushes its expected {err,step,dir} event onto
// exp_q; a negedge monitor pops and compares every step/err pulse the DUT
// emits. Directed checks cover reset state, exact latency, ab_filt, dir and
// err_cnt (including saturation and clear priority).
// -----------------------------------------------------------------------------
module tb_qei_step_decoder;

  localparam int FILT_LEN = 4;
  localparam int ERR_W    = 8;
  localparam int CNT_SAT  = (1 << ERR_W) - 1;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             ena     = 1'b0;
  logic             a_in    = 1'b0;
  logic             b_in    = 1'b0;
  logic             clr_err = 1'b0;
  logic             step;
  logic             dir;
  logic             err;
  logic [1:0]       ab_filt;
  logic [ERR_W-1:0] err_cnt;

  always #5 clk = ~clk;

  qei_step_decoder #(
    .FILT_LEN (FILT_LEN),
    .ERR_W    (ERR_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .a_in    (a_in),
    .b_in    (b_in),
    .clr_err (clr_err),
    .step    (step),
    .dir     (dir),
    .err     (err),
    .ab_filt (ab_filt),
    .err_cnt (err_cnt)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and model
  // ---------------------------------------------------------------------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [2:0] exp_q[$];   // {err, step, dir}
  logic [1:0] m_filt  = 2'b00;
  logic       m_dir   = 1'b0;
  int         m_cnt   = 0;
  logic [2:0] mon_e;

  task automatic check_val(input string tag, input logic [15:0] obs,
                           input logic [15:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Next state of the forward Gray sequence 00->01->11->10->00.
  function automatic logic [1:0] fwd_next(input logic [1:0] x);
    case (x)
      2'b00:   fwd_next = 2'b01;
      2'b01:   fwd_next = 2'b11;
      2'b11:   fwd_next = 2'b10;
      default: fwd_next = 2'b00;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds {A,B}=v for 'hold' sampling edges. Holds >= FILT_LEN+1 are expected
  // to pass the filter, holds <= FILT_LEN-1 to be rejected. With clr set,
  // clr_err is raised over the edges where the resulting err is registered.
  task automatic drive_ab(input logic [1:0] v, input int hold, input bit clr);
    logic [1:0] prev_f;
    {a_in, b_in} = v;
    if (hold >= FILT_LEN + 1 && v != m_filt) begin
      prev_f = m_filt;
      if (v == fwd_next(prev_f)) begin
        if (ena) begin
          m_dir = 1'b1;
          exp_q.push_back(3'b011);
        end
      end else if (prev_f == fwd_next(v)) begin
        if (ena) begin
          m_dir = 1'b0;
          exp_q.push_back(3'b010);
        end
      end else if (ena) begin
        exp_q.push_back({1'b1, 1'b0, m_dir});
        if (clr)                  m_cnt = 0;
        else if (m_cnt < CNT_SAT) m_cnt++;
      end
      m_filt = v;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (clr && i == 4) clr_err = 1'b1;
      if (clr && i == 7) clr_err = 1'b0;
    end
    if (hold >= 8) begin
      check_val("ab_filt", 16'(ab_filt), 16'(m_filt));
      check_val("dir",     16'(dir),     16'(m_dir));
    end
  endtask

  task automatic do_reset(input logic [1:0] pins);
    rst_n = 1'b0;
    {a_in, b_in} = pins;
    wait_cyc(4);
    check_val("rst_step",    16'(step),    16'h0);
    check_val("rst_dir",     16'(dir),     16'h0);
    check_val("rst_err",     16'(err),     16'h0);
    check_val("rst_ab_filt", 16'(ab_filt), 16'h0);
    check_val("rst_err_cnt", 16'(err_cnt), 16'h0);
    m_filt = pins;
    m_dir  = 1'b0;
    m_cnt  = 0;
    rst_n  = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: every step/err pulse must match the head of exp_q
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && (step || err)) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_pulse", 16'({err, step, dir}), 16'h0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("pulse", 16'({err, step, dir}), 16'(mon_e));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    @(posedge clk);
    #1;
    do_reset(2'b00);
    ena = 1'b1;
    wait_cyc(12);

    // Exact latency: change seen first at E0, ab_filt at E5, step at E6.
    {a_in, b_in} = 2'b01;
    m_filt = 2'b01;
    m_dir  = 1'b1;
    exp_q.push_back(3'b011);
    @(posedge clk);               // E0
    repeat (4) @(posedge clk);    // E4
    #1;
    check_val("lat_filt_e4", 16'(ab_filt), 16'h0);
    @(posedge clk);               // E5
    #1;
    check_val("lat_filt_e5", 16'(ab_filt), 16'h1);
    check_val("lat_step_e5", 16'(step),    16'h0);
    @(posedge clk);               // E6
    #1;
    check_val("lat_step_e6", 16'(step), 16'h1);
    check_val("lat_dir_e6",  16'(dir),  16'h1);
    @(posedge clk);               // E7
    #1;
    check_val("lat_step_e7", 16'(step), 16'h0);
    wait_cyc(8);

    // Back to 00, then a full forward and a full reverse cycle.
    drive_ab(2'b00, 16, 1'b0);
    drive_ab(2'b01, 16, 1'b0);
    drive_ab(2'b11, 16, 1'b0);
    drive_ab(2'b10, 16, 1'b0);
    drive_ab(2'b00, 16, 1'b0);
    drive_ab(2'b10, 16, 1'b0);
    drive_ab(2'b11, 16, 1'b0);
    drive_ab(2'b01, 16, 1'b0);
    drive_ab(2'b00, 16, 1'b0);
    check_val("err_cnt_after_cycles", 16'(err_cnt), 16'(m_cnt));

    // Glitch rejection, then a pulse long enough to pass both edges.
    drive_ab(2'b10, 3, 1'b0);
    drive_ab(2'b00, 16, 1'b0);
    drive_ab(2'b01, 6, 1'b0);
    drive_ab(2'b00, 16, 1'b0);

    // Illegal jumps: single err, saturation, clear priority.
    drive_ab(2'b11, 16, 1'b0);
    check_val("err_cnt_one", 16'(err_cnt), 16'h1);
    for (int k = 0; k < 299; k++) begin
      drive_ab((k % 2 == 0) ? 2'b00 : 2'b11, 6, 1'b0);
    end
    wait_cyc(4);
    check_val("err_cnt_sat_model", 16'(err_cnt), 16'(m_cnt));
    check_val("err_cnt_sat",       16'(err_cnt), 16'(CNT_SAT));
    drive_ab((m_filt == 2'b00) ? 2'b11 : 2'b00, 16, 1'b1);
    check_val("err_cnt_clr", 16'(err_cnt), 16'h0);

    // Reset released with pins at 11: no pulses, filter settles to 11.
    wait_cyc(4);
    do_reset(2'b11);
    wait_cyc(5);
    check_val("r11_filt_e4", 16'(ab_filt), 16'h0);
    wait_cyc(1);
    check_val("r11_filt_e5", 16'(ab_filt), 16'h3);
    wait_cyc(12);
    check_val("r11_err_cnt", 16'(err_cnt), 16'h0);

    // Disabled forward cycle, re-enable, then one live forward step.
    ena = 1'b0;
    drive_ab(2'b10, 16, 1'b0);
    drive_ab(2'b00, 16, 1'b0);
    drive_ab(2'b01, 16, 1'b0);
    drive_ab(2'b11, 16, 1'b0);
    ena = 1'b1;
    wait_cyc(20);
    check_val("reena_step", 16'(step), 16'h0);
    drive_ab(2'b10, 16, 1'b0);

    wait_cyc(10);
    check_val("exp_q_empty",   16'(exp_q.size()), 16'h0);
    check_val("err_cnt_final", 16'(err_cnt),      16'(m_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
